// File: rtl/ddr2_clk_rst_seq.sv
// Clock/reset supervisor for the DDR2 interface.
// Pulses the DCM reset, waits for DCM lock and IDELAYCTRL ready, requires
// both to hold for a qualification window, then releases the DDR2 reset.
// Lock timeouts and lock loss re-pulse the DCM reset up to MAX_RETRY times
// before the sequencer parks in FAIL.
module ddr2_clk_rst_seq #(
  parameter int unsigned DCM_RST_CYC  = 4,
  parameter int unsigned LOCK_TIMEOUT = 1000,
  parameter int unsigned STABLE_CYC   = 16,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned RTY_W        = 2
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             dcm_locked,
  input  logic             idelay_ctrl_rdy,
  output logic             dcm_rst,
  output logic             ddr2_rst,
  output logic             init_done,
  output logic             seq_err,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [2:0]       state
);

  localparam logic [2:0] ST_DCM_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_WAIT_IDLY = 3'd2;
  localparam logic [2:0] ST_STABLE    = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_FAIL      = 3'd5;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(DCM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRY);

  logic             lk_m;
  logic             lk_s;
  logic             rd_m;
  logic             rd_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       state_nxt;
  logic [RTY_W-1:0] rty_nxt;
  logic             take_retry;
  logic             counting;

  // Two-flop synchronisers for the 200 MHz-domain status inputs
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
      rd_m <= 1'b0;
      rd_s <= 1'b0;
    end else begin
      lk_m <= dcm_locked;
      lk_s <= lk_m;
      rd_m <= idelay_ctrl_rdy;
      rd_s <= rd_m;
    end
  end

  // Next-state, retry accounting and shared cycle counter
  always_comb begin
    state_nxt  = state;
    rty_nxt    = retry_cnt;
    take_retry = 1'b0;
    counting   = 1'b0;

    case (state)
      ST_DCM_RST: begin
        counting = 1'b1;
        if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        counting = 1'b1;
        if (lk_s)                 state_nxt  = ST_WAIT_IDLY;
        else if (cnt == TMO_LAST) take_retry = 1'b1;
      end
      ST_WAIT_IDLY: begin
        counting = 1'b1;
        if (!lk_s)                take_retry = 1'b1;
        else if (rd_s)            state_nxt  = ST_STABLE;
        else if (cnt == TMO_LAST) take_retry = 1'b1;
      end
      ST_STABLE: begin
        counting = 1'b1;
        if (!lk_s)                   take_retry = 1'b1;
        else if (!rd_s)              state_nxt  = ST_WAIT_IDLY;
        else if (cnt == STABLE_LAST) state_nxt  = ST_RUN;
      end
      ST_RUN: begin
        // Simultaneous loss of both inputs is treated as lock loss
        if (!lk_s)      take_retry = 1'b1;
        else if (!rd_s) state_nxt  = ST_WAIT_IDLY;
      end
      ST_FAIL: begin
        state_nxt = ST_FAIL;
      end
      default: begin
        state_nxt = ST_DCM_RST;
      end
    endcase

    if (take_retry) begin
      if (retry_cnt < RTY_MAX) begin
        rty_nxt   = retry_cnt + RTY_W'(1);
        state_nxt = ST_DCM_RST;
      end else begin
        state_nxt = ST_FAIL;
      end
    end

    // Counter restarts on every state entry
    if (state_nxt != state) cnt_nxt = '0;
    else if (counting)      cnt_nxt = cnt + CNT_W'(1);
    else                    cnt_nxt = cnt;
  end

  // State, counter and retry registers
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state     <= ST_DCM_RST;
      cnt       <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= rty_nxt;
    end
  end

  // Registered output decode, one cycle behind the state register
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      dcm_rst   <= 1'b1;
      ddr2_rst  <= 1'b1;
      init_done <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      dcm_rst   <= (state == ST_DCM_RST);
      ddr2_rst  <= (state != ST_RUN);
      init_done <= (state == ST_RUN);
      seq_err   <= (state == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_ddr2_clk_rst_seq.sv
// Directed testbench for ddr2_clk_rst_seq with reduced timing parameters.
// Cycle c is the c-th rising edge after rst release; outputs are sampled
// 1 ns after that edge and inputs are changed at the same point.
module tb_ddr2_clk_rst_seq;

  localparam int unsigned RTY_W = 2;

  logic             clk_100MHz = 1'b0;
  logic             rst;
  logic             dcm_locked;
  logic             idelay_ctrl_rdy;
  logic             dcm_rst;
  logic             ddr2_rst;
  logic             init_done;
  logic             seq_err;
  logic [RTY_W-1:0] retry_cnt;
  logic [2:0]       state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  ddr2_clk_rst_seq #(
    .DCM_RST_CYC (4),
    .LOCK_TIMEOUT(20),
    .STABLE_CYC  (8),
    .MAX_RETRY   (2),
    .CNT_W       (16),
    .RTY_W       (RTY_W)
  ) dut (
    .clk_100MHz     (clk_100MHz),
    .rst            (rst),
    .dcm_locked     (dcm_locked),
    .idelay_ctrl_rdy(idelay_ctrl_rdy),
    .dcm_rst        (dcm_rst),
    .ddr2_rst       (ddr2_rst),
    .init_done      (init_done),
    .seq_err        (seq_err),
    .retry_cnt      (retry_cnt),
    .state          (state)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    dcm_locked      = 1'b0;
    idelay_ctrl_rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},     int'(state),     0);
    chk({tag, "_retry"},     int'(retry_cnt), 0);
    chk({tag, "_dcm_rst"},   int'(dcm_rst),   1);
    chk({tag, "_ddr2_rst"},  int'(ddr2_rst),  1);
    chk({tag, "_init_done"}, int'(init_done), 0);
    chk({tag, "_seq_err"},   int'(seq_err),   0);
  endtask

  // Hand-derived state timeline for each scenario
  function automatic int exp_state(input int t, input int c);
    if (c < 4) return 0;
    case (t)
      1: begin
        if (c < 13) return 1;
        if (c < 18) return 2;
        if (c < 26) return 3;
        return 4;
      end
      2: begin
        if (c < 24) return 1;
        if (c < 28) return 0;
        if (c < 48) return 1;
        if (c < 52) return 0;
        if (c < 72) return 1;
        return 5;
      end
      default: begin
        if (c < 13)  return 1;
        if (c < 18)  return 2;
        if (c < 23)  return 3;
        if (c < 26)  return 2;
        if (c < 34)  return 3;
        if (c < 43)  return 4;
        if (c < 47)  return 0;
        if (c == 47) return 1;
        if (c == 48) return 2;
        if (c < 57)  return 3;
        if (c < 63)  return 4;
        if (c < 67)  return 0;
        if (c == 67) return 1;
        if (c == 68) return 2;
        if (c < 77)  return 3;
        if (c < 83)  return 4;
        return 5;
      end
    endcase
  endfunction

  function automatic int exp_retry(input int t, input int c);
    case (t)
      1:       return 0;
      2:       return (c < 24) ? 0 : (c < 48) ? 1 : 2;
      default: return (c < 43) ? 0 : (c < 63) ? 1 : 2;
    endcase
  endfunction

  task automatic apply_stim(input int t, input int c);
    if (t == 1 || t == 3) begin
      if (c == 10) dcm_locked      = 1'b1;
      if (c == 15) idelay_ctrl_rdy = 1'b1;
    end
    if (t == 3) begin
      case (c)
        20: idelay_ctrl_rdy = 1'b0;
        23: idelay_ctrl_rdy = 1'b1;
        40: dcm_locked      = 1'b0;
        44: dcm_locked      = 1'b1;
        60: begin dcm_locked = 1'b0; idelay_ctrl_rdy = 1'b0; end
        64: begin dcm_locked = 1'b1; idelay_ctrl_rdy = 1'b1; end
        80: dcm_locked      = 1'b0;
        default: ;
      endcase
    end
  endtask

  // Walk cycles 1..last checking every output against the timeline
  task automatic run_trace(input int t, input int last);
    int p;
    for (int c = 1; c <= last; c++) begin
      run_to(c);
      p = exp_state(t, c - 1);
      chk($sformatf("t%0d_c%0d_state", t, c),     int'(state),     exp_state(t, c));
      chk($sformatf("t%0d_c%0d_retry", t, c),     int'(retry_cnt), exp_retry(t, c));
      chk($sformatf("t%0d_c%0d_dcm_rst", t, c),   int'(dcm_rst),   (p == 0) ? 1 : 0);
      chk($sformatf("t%0d_c%0d_ddr2_rst", t, c),  int'(ddr2_rst),  (p != 4) ? 1 : 0);
      chk($sformatf("t%0d_c%0d_init_done", t, c), int'(init_done), (p == 4) ? 1 : 0);
      chk($sformatf("t%0d_c%0d_seq_err", t, c),   int'(seq_err),   (p == 5) ? 1 : 0);
      apply_stim(t, c);
    end
  endtask

  // Pulse rst for one cycle from the current state and check async effect
  task automatic pulse_rst(input string tag);
    rst             = 1'b1;
    dcm_locked      = 1'b0;
    idelay_ctrl_rdy = 1'b0;
    #1;
    chk_reset_vals(tag);
    @(posedge clk_100MHz);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int bad;

    // Scenario 1: clean bring-up
    do_reset();
    chk_reset_vals("reset");
    run_trace(1, 30);

    // Scenario 6a: rst in RUN, then bring-up repeats
    pulse_rst("rst_in_run");
    run_trace(1, 30);

    // Scenario 2: lock timeout until FAIL
    do_reset();
    run_trace(2, 73);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (state != 3'd5 || dcm_rst != 1'b0 || ddr2_rst != 1'b1 ||
          seq_err != 1'b1 || init_done != 1'b0 || retry_cnt != 2'd2) bad++;
    end
    chk("fail_hold_bad_cycles", bad, 0);

    // Scenario 6b: rst in FAIL, then bring-up repeats
    pulse_rst("rst_in_fail");
    run_trace(1, 30);

    // Scenarios 3-5: ready dropout, lock loss, double drop, final FAIL
    do_reset();
    run_trace(3, 86);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
